rxn_game_ctrl: RTL and testbench

Sequencing controller for the reaction-time game. It decodes the start op_code and waits a pseudo-random delay. It then raises the stimulus for the VGA drawer and times the player's keypress in milliseconds using BCD counters. It drives the 5-character ASCII display word and the result to the terminal top level.

---
 rtl/rxn_game_ctrl.sv | 246 ++++++++++++++++++++++++
 tb/tb_rxn_game_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rxn_game_ctrl.sv
// rxn_game_ctrl: sequencing controller for the reaction-time game.
// Waits a pseudo-random delay after a start op code, lights the stimulus,
// times the response key in BCD milliseconds and drives the 5-char ASCII
// display word plus the result to the terminal top level.
module rxn_game_ctrl #(
  parameter int unsigned TICK_DIV     = 100000,
  parameter logic [10:0] START_OP     = 11'b00100000000,
  parameter logic [7:0]  RESP_KEY     = 8'h20,
  parameter int unsigned MIN_DELAY_MS = 1000,
  parameter int unsigned DELAY_BITS   = 11,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] op_code,
  input  logic [7:0]  a,
  input  logic        a_valid,
  output logic        stim_on,
  output logic        busy,
  output logic [15:0] result_bcd,
  output logic        result_valid,
  output logic        early,
  output logic [39:0] display,
  output logic [2:0]  state
);

  // FSM state encodings (these values are also visible on the state port)
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ARM   = 3'd1;
  localparam logic [2:0] ST_GO    = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_EARLY = 3'd4;
  localparam logic [2:0] ST_SLOW  = 3'd5;

  // ASCII display words, leftmost character in the top byte
  localparam logic [39:0] TXT_READY = 40'h5245414459;
  localparam logic [39:0] TXT_WAIT  = 40'h5741495420;
  localparam logic [39:0] TXT_GO    = 40'h474F212020;
  localparam logic [39:0] TXT_EARLY = 40'h4541524C59;
  localparam logic [39:0] TXT_SLOW  = 40'h534C4F5720;

  // Counter widths derived from the parameters
  localparam int unsigned PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DELAY_MAX = MIN_DELAY_MS + (2 ** DELAY_BITS) - 1;
  localparam int unsigned DW        = $clog2(DELAY_MAX + 1);

  // An all-zero Galois LFSR would lock up, so a zero seed is replaced
  localparam logic [15:0] SEED_EFF  = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [15:0] LFSR_MASK = 16'hB400;
  localparam logic [15:0] BCD_MAX   = 16'h9999;

  // Registered state
  logic [2:0]    state_r;
  logic [10:0]   prev_op_r;
  logic [15:0]   lfsr_r;
  logic [PW-1:0] presc_r;
  logic [DW-1:0] delay_r;
  logic [15:0]   count_r;
  logic [15:0]   result_r;
  logic          result_valid_r;
  logic          stim_on_r;
  logic          busy_r;
  logic          early_r;
  logic [39:0]   display_r;

  // Combinational next-state values
  logic          start_s;
  logic          press_s;
  logic          tick_s;
  logic          enter_timed_s;
  logic [2:0]    state_nxt_s;
  logic [DW-1:0] delay_nxt_s;
  logic [DW-1:0] delay_load_s;
  logic [15:0]   count_nxt_s;
  logic [15:0]   result_nxt_s;
  logic          result_valid_nxt_s;
  logic [15:0]   lfsr_nxt_s;
  logic [PW-1:0] presc_nxt_s;
  logic [39:0]   display_nxt_s;

  // Add one to a 4-digit packed BCD value with decimal carry
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
          carry       = 1'b1;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // One Galois LFSR step, taps given by LFSR_MASK
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? LFSR_MASK : 16'h0000);
  endfunction

  // Render four BCD digits as ASCII followed by a space
  function automatic logic [39:0] bcd_text(input logic [15:0] v);
    return {4'h3, v[15:12], 4'h3, v[11:8], 4'h3, v[7:4], 4'h3, v[3:0], 8'h20};
  endfunction

  // Edge-detect the level-held op code so a held start counts once
  assign start_s      = (op_code == START_OP) && (prev_op_r != START_OP);
  assign press_s      = a_valid && (a == RESP_KEY);
  assign tick_s       = (presc_r == PW'(TICK_DIV - 1));
  assign delay_load_s = DW'(MIN_DELAY_MS) + DW'(lfsr_r[DELAY_BITS-1:0]);
  assign lfsr_nxt_s   = lfsr_step(lfsr_r);

  // Sequencing FSM: next state, delay down-counter, BCD timer and result
  always_comb begin
    state_nxt_s        = state_r;
    delay_nxt_s        = delay_r;
    count_nxt_s        = count_r;
    result_nxt_s       = result_r;
    result_valid_nxt_s = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE, ST_EARLY, ST_SLOW: begin
        if (start_s) begin
          state_nxt_s = ST_ARM;
          delay_nxt_s = delay_load_s;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_ARM: begin
        // An early press wins over delay expiry in the same cycle
        if (press_s) begin
          state_nxt_s = ST_EARLY;
        end else if (tick_s) begin
          if (delay_r <= DW'(1)) begin
            state_nxt_s = ST_GO;
            delay_nxt_s = '0;
            count_nxt_s = 16'h0000;
          end else begin
            delay_nxt_s = delay_r - DW'(1);
          end
        end else begin
          delay_nxt_s = delay_r;
        end
      end
      ST_GO: begin
        // A tick coinciding with the press is deliberately not counted
        if (press_s) begin
          state_nxt_s        = ST_DONE;
          result_nxt_s       = count_r;
          result_valid_nxt_s = 1'b1;
        end else if (tick_s) begin
          if (count_r == BCD_MAX) begin
            state_nxt_s        = ST_SLOW;
            result_nxt_s       = BCD_MAX;
            result_valid_nxt_s = 1'b1;
          end else begin
            count_nxt_s = bcd_inc(count_r);
          end
        end else begin
          count_nxt_s = count_r;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Millisecond prescaler, restarted on every entry to ARM or GO
  always_comb begin
    enter_timed_s = (state_nxt_s != state_r) &&
                    ((state_nxt_s == ST_ARM) || (state_nxt_s == ST_GO));
    if (enter_timed_s) begin
      presc_nxt_s = '0;
    end else if (tick_s) begin
      presc_nxt_s = '0;
    end else begin
      presc_nxt_s = presc_r + PW'(1);
    end
  end

  // Display word for the state being entered, so it lines up with state
  always_comb begin
    case (state_nxt_s)
      ST_IDLE:  display_nxt_s = TXT_READY;
      ST_ARM:   display_nxt_s = TXT_WAIT;
      ST_GO:    display_nxt_s = TXT_GO;
      ST_DONE:  display_nxt_s = bcd_text(result_nxt_s);
      ST_EARLY: display_nxt_s = TXT_EARLY;
      ST_SLOW:  display_nxt_s = TXT_SLOW;
      default:  display_nxt_s = TXT_READY;
    endcase
  end

  // Control and timing registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      prev_op_r <= 11'd0;
      lfsr_r    <= SEED_EFF;
      presc_r   <= '0;
      delay_r   <= '0;
      count_r   <= 16'h0000;
    end else begin
      state_r   <= state_nxt_s;
      prev_op_r <= op_code;
      lfsr_r    <= lfsr_nxt_s;
      presc_r   <= presc_nxt_s;
      delay_r   <= delay_nxt_s;
      count_r   <= count_nxt_s;
    end
  end

  // Output registers, decoded from the next state so they change with it
  always_ff @(posedge clk) begin
    if (reset) begin
      result_r       <= 16'h0000;
      result_valid_r <= 1'b0;
      stim_on_r      <= 1'b0;
      busy_r         <= 1'b0;
      early_r        <= 1'b0;
      display_r      <= TXT_READY;
    end else begin
      result_r       <= result_nxt_s;
      result_valid_r <= result_valid_nxt_s;
      stim_on_r      <= (state_nxt_s == ST_GO);
      busy_r         <= (state_nxt_s == ST_ARM) || (state_nxt_s == ST_GO);
      early_r        <= (state_nxt_s == ST_EARLY);
      display_r      <= display_nxt_s;
    end
  end

  assign state        = state_r;
  assign stim_on      = stim_on_r;
  assign busy         = busy_r;
  assign result_bcd   = result_r;
  assign result_valid = result_valid_r;
  assign early        = early_r;
  assign display      = display_r;

endmodule

// File: tb/tb_rxn_game_ctrl.sv
// Self-checking bench for rxn_game_ctrl: a millisecond-level game model
// predicts every output each cycle, and directed scenarios pin literal values.
module tb_rxn_game_ctrl;

  localparam int          TD       = 4;
  localparam int          MIN_MS   = 3;
  localparam int          DBITS    = 2;
  localparam logic [10:0] START_OP = 11'b00100000000;
  localparam logic [7:0]  SPACE    = 8'h20;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] op_code;
  logic [7:0]  a;
  logic        a_valid;
  logic        stim_on;
  logic        busy;
  logic [15:0] result_bcd;
  logic        result_valid;
  logic        early;
  logic [39:0] display;
  logic [2:0]  state;

  int checks   = 0;
  int failures = 0;

  rxn_game_ctrl #(
    .TICK_DIV(TD), .START_OP(START_OP), .RESP_KEY(SPACE),
    .MIN_DELAY_MS(MIN_MS), .DELAY_BITS(DBITS), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk), .reset(reset), .op_code(op_code), .a(a), .a_valid(a_valid),
    .stim_on(stim_on), .busy(busy), .result_bcd(result_bcd),
    .result_valid(result_valid), .early(early), .display(display), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- behavioural game model (phase numbers = state port) ----
  bit          m_known = 0;
  int          m_phase, m_cyc, m_wait, m_elapsed, m_result;
  bit          m_rv;
  logic [15:0] m_lfsr;
  logic [10:0] m_prev;

  // monitor counters
  int  arm_entries = 0;
  int  rv_pulses   = 0;
  bit  stim_seen   = 0;
  bit  busy_prev   = 0;

  function automatic logic [15:0] to_bcd(input int n);
    return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
  endfunction

  function automatic logic [39:0] text_for(input int ph, input int res);
    logic [39:0] w;
    case (ph)
      1:       w = "WAIT ";
      2:       w = "GO!  ";
      3:       w = {8'(48 + res / 1000 % 10), 8'(48 + res / 100 % 10),
                    8'(48 + res / 10 % 10), 8'(48 + res % 10), 8'h20};
      4:       w = "EARLY";
      5:       w = "SLOW ";
      default: w = "READY";
    endcase
    return w;
  endfunction

  function automatic logic [62:0] model_outputs();
    return {3'(m_phase), m_phase == 2, (m_phase == 1) || (m_phase == 2), m_phase == 4,
            m_rv, to_bcd(m_result), text_for(m_phase, m_result)};
  endfunction

  // Advance the model by one clock using the inputs the DUT will sample next
  task automatic model_step();
    bit start, press, tick;
    int next_cyc;
    start = (op_code == START_OP) && (m_prev != START_OP);
    press = a_valid && (a == SPACE);
    tick  = (m_cyc % TD) == (TD - 1);
    if (reset) begin
      m_known = 1; m_phase = 0; m_cyc = 0; m_wait = 0; m_elapsed = 0;
      m_result = 0; m_rv = 0; m_lfsr = 16'hACE1; m_prev = 11'd0;
      return;
    end
    next_cyc = m_cyc + 1;
    m_rv = 0;
    case (m_phase)
      1: begin
        if (press) m_phase = 4;
        else if (tick) begin
          m_wait--;
          if (m_wait == 0) begin m_phase = 2; m_elapsed = 0; next_cyc = 0; end
        end
      end
      2: begin
        if (press) begin m_phase = 3; m_result = m_elapsed; m_rv = 1; end
        else if (tick) begin
          if (m_elapsed == 9999) begin m_phase = 5; m_result = 9999; m_rv = 1; end
          else m_elapsed++;
        end
      end
      default: begin
        if (start) begin
          m_phase = 1; m_wait = MIN_MS + (m_lfsr % (1 << DBITS)); next_cyc = 0;
        end
      end
    endcase
    m_cyc  = next_cyc;
    m_lfsr = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    m_prev = op_code;
  endtask

  // Compare every cycle on the falling edge, then predict the next edge
  initial begin
    forever begin
      @(negedge clk);
      if (m_known)
        chk("cycle_outputs",
            {1'b0, state, stim_on, busy, early, result_valid, result_bcd, display},
            {1'b0, model_outputs()});
      if (busy === 1'b1 && !busy_prev && state === 3'd1) arm_entries++;
      busy_prev = (busy === 1'b1);
      if (result_valid === 1'b1) rv_pulses++;
      if (stim_on === 1'b1) stim_seen = 1;
      model_step();
    end
  end

  // ---------------- directed + random stimulus --------------------------
  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_stim(input int bound, output int n);
    n = 0;
    while (stim_on !== 1'b1 && n < bound) begin step(); n++; end
    chk("timeout_stim_on", stim_on, 1'b1);
  endtask

  task automatic wait_busy(input int bound);
    int n = 0;
    while (busy !== 1'b1 && n < bound) begin step(); n++; end
    chk("timeout_busy", busy, 1'b1);
  endtask

  task automatic press_key(input logic [7:0] key);
    a = key; a_valid = 1'b1; step(); a_valid = 1'b0; a = 8'h00;
  endtask

  task automatic new_start();
    op_code = 11'd0; step(); op_code = START_OP;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, rv0, arm0, held;
    reset = 1'b1; op_code = 11'd0; a = 8'h00; a_valid = 1'b0;
    // 1: reset
    step(3);
    chk("reset_display", display, 40'h5245414459);
    chk("reset_stim", stim_on, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_result", result_bcd, 16'h0000);
    chk("reset_state", state, 3'd0);
    reset = 1'b0;
    while ($time < 100) step();
    // 2: 37 ms reaction
    op_code = START_OP;
    wait_stim(100, n);
    step(148);
    rv0 = rv_pulses;
    press_key(SPACE);
    chk("t2_result", result_bcd, 16'h0037);
    chk("t2_rvalid", result_valid, 1'b1);
    chk("t2_display", display, 40'h3030333720);
    chk("t2_stim_off", stim_on, 1'b0);
    step();
    chk("t2_rvalid_1cyc", result_valid, 1'b0);
    chk("t2_rv_count", rv_pulses - rv0, 1);
    // 3: early press in ARM
    new_start();
    stim_seen = 0;
    wait_busy(10);
    step(2);
    press_key(SPACE);
    chk("t3_state", state, 3'd4);
    chk("t3_early", early, 1'b1);
    chk("t3_display", display, 40'h4541524C59);
    chk("t3_result_kept", result_bcd, 16'h0037);
    press_key(SPACE);
    step(20);
    chk("t3_still_early", state, 3'd4);
    chk("t3_stim_never", stim_seen, 1'b0);
    // 5: held start, ARM span, non-space key ignored
    op_code = 11'd0; step();
    arm0 = arm_entries;
    op_code = START_OP;
    wait_busy(10);
    wait_stim(100, n);
    chk("t5_arm_whole_ticks", n % TD, 0);
    chk("t5_arm_range", (n / TD >= 3) && (n / TD <= 6), 1'b1);
    press_key(8'h41);
    chk("t5_key_ignored", state, 3'd2);
    held = n + 3;
    if (held < 50) step(50 - held);
    chk("t5_one_arm", arm_entries - arm0, 1);
    press_key(SPACE);
    chk("t5_done", state, 3'd3);
    // 4: no press -> SLOW
    new_start();
    wait_stim(100, n);
    rv0 = rv_pulses;
    n = 0;
    while (result_valid !== 1'b1 && n < 10000 * TD + 100) begin step(); n++; end
    chk("t4_rvalid", result_valid, 1'b1);
    chk("t4_state", state, 3'd5);
    chk("t4_result", result_bcd, 16'h9999);
    chk("t4_display", display, 40'h534C4F5720);
    step(5);
    chk("t4_one_pulse", rv_pulses - rv0, 1);
    // 6a: press coincident with tick at 0012
    new_start();
    wait_stim(100, n);
    step(51);
    press_key(SPACE);
    chk("t6_tick_press", result_bcd, 16'h0012);
    // 6b: reset in GO
    new_start();
    wait_stim(100, n);
    step(10);
    reset = 1'b1; step(); reset = 1'b0;
    chk("t6_reset_state", state, 3'd0);
    chk("t6_reset_stim", stim_on, 1'b0);
    chk("t6_reset_display", display, 40'h5245414459);
    // random phase, all checked against the model
    for (int i = 0; i < 3000; i++) begin
      op_code = ($urandom_range(0, 9) < 3) ? START_OP : 11'($urandom_range(0, 2047));
      a_valid = ($urandom_range(0, 29) == 0);
      a       = $urandom_range(0, 1) ? SPACE : 8'($urandom_range(0, 255));
      reset   = ($urandom_range(0, 499) == 0);
      step();
    end
    reset = 1'b0; a_valid = 1'b0; op_code = 11'd0;
    step(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
